// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
// Pointer-to-level math lives here so a write-side monitor can reuse it.
package fifo_rd_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam int N_DEF     = 16;
  localparam int DEPTH_DEF = 32'h6800;

  // Occupancy from wrap-bit pointers; caller truncates to pointer width.
  function automatic logic [31:0] ptr_level(
    input logic [31:0] wr,
    input logic [31:0] rd,
    input logic [31:0] depth,
    input int          n
  );
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << (n - 1)) - 32'd1;
    diff = (wr ^ rd) >> (n - 1);
    if (diff[0] == 1'b0)
      ptr_level = (wr & mask) - (rd & mask);
    else
      ptr_level = depth - (rd & mask) + (wr & mask);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Round-robin first-set-bit picker: scans upward from last+1, modulo NREQ.
// Purely combinational so other arbiters can drop it in.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  logic [IDW-1:0] j;

  // Walk from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      j = IDW'((int'(last) + i) % NREQ);
      if (req[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter for the FIFO read port, with read-valid pipe.
// Define FIFO_RD_ARB_PRIO0_EN to give requester 0 strict priority in IDLE.
module fifo_rd_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                    rdClk,
  input  logic                    rdRst,
  input  logic [NREQ-1:0]         req,
  input  logic                    fifoEmpty,
  input  logic [N-1:0]            wrPtr,
  input  logic [N-1:0]            rdPtr,
  output logic                    rdEn,
  output logic [NREQ-1:0]         gnt,
  output logic                    rdValid,
  output logic [$clog2(NREQ)-1:0] rdId,
  output logic [N-1:0]            level
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [7:0] CNT_LAST = 8'(BURST_MAX - 1);

  state_t         state, state_n;
  logic [IDW-1:0] owner, owner_n;
  logic [IDW-1:0] last_owner, last_n;
  logic [7:0]     burst_cnt, cnt_n;
  logic [IDW-1:0] rr_idx, pick_idx;
  logic           rr_vld;

  logic [RD_LAT-1:0] en_pipe;
  logic [IDW-1:0]    id_pipe [RD_LAT];

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req),
    .last  (last_owner),
    .idx   (rr_idx),
    .valid (rr_vld)
  );

`ifdef FIFO_RD_ARB_PRIO0_EN
  assign pick_idx = req[0] ? '0 : rr_idx;
`else
  assign pick_idx = rr_idx;
`endif

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    cnt_n   = burst_cnt;
    gnt     = '0;
    rdEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rr_vld) begin
          owner_n = pick_idx;
          cnt_n   = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        gnt[owner] = 1'b1;
        rdEn = req[owner] & ~fifoEmpty;
        if (rdEn)
          cnt_n = burst_cnt + 8'd1;
        // Final read of a full burst still issues this cycle.
        if (!req[owner] || (rdEn && burst_cnt == CNT_LAST)) begin
          state_n = IDLE;
          last_n  = owner;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rdClk) begin
    if (rdRst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDW'(NREQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      burst_cnt  <= cnt_n;
    end
  end

  // Reset drops any read still in flight.
  always_ff @(posedge rdClk) begin
    if (rdRst) begin
      en_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++)
        id_pipe[i] <= '0;
    end else begin
      en_pipe[0] <= rdEn;
      id_pipe[0] <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        id_pipe[i] <= id_pipe[i-1];
      end
    end
  end

  assign rdValid = en_pipe[RD_LAT-1];
  assign rdId    = id_pipe[RD_LAT-1];

  always_ff @(posedge rdClk) begin
    if (rdRst)
      level <= '0;
    else
      level <= N'(ptr_level(32'(wrPtr), 32'(rdPtr),
                            32'(DEPTH), N));
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter; behavioural read unit tracks entries.
// Expected owner in the priority step follows FIFO_RD_ARB_PRIO0_EN.
module tb_fifo_rd_arbiter;

  logic        rdClk;
  logic        rdRst;
  logic [3:0]  req;
  logic        fifoEmpty;
  logic [15:0] wrPtr;
  logic [15:0] rdPtr;
  logic        rdEn;
  logic [3:0]  gnt;
  logic        rdValid;
  logic [1:0]  rdId;
  logic [15:0] level;

  int          checks = 0;
  int          errors = 0;
  int          fcnt   = 0;
  logic [1:0]  exp_own = 2'd0;
  logic [3:0]  own_mask;

  fifo_rd_arbiter dut (
    .rdClk     (rdClk),
    .rdRst     (rdRst),
    .req       (req),
    .fifoEmpty (fifoEmpty),
    .wrPtr     (wrPtr),
    .rdPtr     (rdPtr),
    .rdEn      (rdEn),
    .gnt       (gnt),
    .rdValid   (rdValid),
    .rdId      (rdId),
    .level     (level)
  );

  initial begin
    rdClk = 1'b0;
    forever #5 rdClk = ~rdClk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; models the read unit and checks the valid pipe.
  task automatic cyc();
    logic       pen;
    logic       prst;
    logic [1:0] pown;
    pen  = rdEn;
    prst = rdRst;
    pown = exp_own;
    @(posedge rdClk);
    #1;
    if (pen && fcnt > 0) fcnt--;
    fifoEmpty = (fcnt == 0);
    #1;
    chk("rdValid", {31'd0, rdValid}, {31'd0, pen & ~prst});
    if (pen & ~prst)
      chk("rdId", {30'd0, rdId}, {30'd0, pown});
  endtask

  task automatic burst_reads(input int n, input logic [1:0] o);
    own_mask = 4'b0001 << o;
    for (int k = 0; k < n; k++) begin
      chk("burst_gnt", {28'd0, gnt}, {28'd0, own_mask});
      chk("burst_rdEn", {31'd0, rdEn}, 32'd1);
      cyc();
    end
  endtask

  initial begin
    rdRst     = 1'b1;
    req       = 4'b0000;
    fifoEmpty = 1'b1;
    wrPtr     = 16'h0000;
    rdPtr     = 16'h0000;
    cyc();
    cyc();
    rdRst = 1'b0;
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_rdEn", {31'd0, rdEn}, 32'd0);
    chk("rst_rdValid", {31'd0, rdValid}, 32'd0);
    chk("rst_rdId", {30'd0, rdId}, 32'd0);
    chk("rst_level", {16'd0, level}, 32'd0);

    // Level across the wrap bit, equal pointers and full.
    wrPtr = 16'h8005; rdPtr = 16'h6700;
    cyc();
    chk("lvl_wrap", {16'd0, level}, 32'h0105);
    wrPtr = 16'h0010; rdPtr = 16'h0010;
    cyc();
    chk("lvl_empty", {16'd0, level}, 32'h0000);
    wrPtr = 16'h8010; rdPtr = 16'h0010;
    cyc();
    chk("lvl_full", {16'd0, level}, 32'h6800);
    wrPtr = 16'd20; rdPtr = 16'd0;
    cyc();
    chk("lvl_20", {16'd0, level}, 32'd20);

    // Burst limit with a lone requester.
    fcnt = 20; fifoEmpty = 1'b0;
    exp_own = 2'd0;
    req = 4'b0001;
    #1;
    chk("bl_idle0", {28'd0, gnt}, 32'd0);
    cyc();
    burst_reads(8, 2'd0);
    chk("bl_gap_gnt", {28'd0, gnt}, 32'd0);
    chk("bl_gap_rdEn", {31'd0, rdEn}, 32'd0);
    cyc();
    burst_reads(8, 2'd0);
    req = 4'b0000;
    #1;
    chk("bl_end_gnt", {28'd0, gnt}, 32'd0);
    chk("bl_fcnt", fcnt, 32'd4);
    cyc();

    // Reset on the third cycle of a burst.
    fcnt = 20; fifoEmpty = 1'b0;
    req = 4'b0001;
    #1;
    cyc();
    chk("mr_rdEn1", {31'd0, rdEn}, 32'd1);
    cyc();
    cyc();
    chk("mr_rdEn3", {31'd0, rdEn}, 32'd1);
    rdRst = 1'b1;
    #1;
    cyc();
    chk("mr_gnt", {28'd0, gnt}, 32'd0);
    chk("mr_rdEn", {31'd0, rdEn}, 32'd0);
    chk("mr_level", {16'd0, level}, 32'd0);
    req = 4'b0000;
    rdRst = 1'b0;
    #1;
    cyc();

    // Rotation 0,1,2,3,0 with a gap cycle before each grant.
    fcnt = 100; fifoEmpty = 1'b0;
    req = 4'b1111;
    #1;
    for (int b = 0; b < 5; b++) begin
      exp_own = 2'(b % 4);
      chk("rr_gap", {28'd0, gnt}, 32'd0);
      cyc();
      burst_reads(8, exp_own);
    end
    req = 4'b0000;
    #1;
    chk("rr_fcnt", fcnt, 32'd60);
    cyc();

    // Empty stall: owner 2 keeps the grant while the FIFO is dry.
    fcnt = 3; fifoEmpty = 1'b0;
    exp_own = 2'd2;
    req = 4'b0100;
    #1;
    cyc();
    burst_reads(3, 2'd2);
    for (int k = 0; k < 5; k++) begin
      chk("st_gnt", {28'd0, gnt}, 32'h4);
      chk("st_rdEn", {31'd0, rdEn}, 32'd0);
      cyc();
    end
    fcnt = 1; fifoEmpty = 1'b0;
    #1;
    chk("st_resume", {31'd0, rdEn}, 32'd1);
    cyc();
    chk("st_cnt", {24'd0, dut.burst_cnt}, 32'd4);
    chk("st_gnt_hold", {28'd0, gnt}, 32'h4);
    req = 4'b0000;
    #1;
    cyc();
    chk("st_release", {28'd0, gnt}, 32'd0);

    // Requester 0 rises mid-burst of owner 1.
    fcnt = 50; fifoEmpty = 1'b0;
    exp_own = 2'd3;
    req = 4'b1010;
    #1;
    cyc();
    burst_reads(8, 2'd3);
    chk("p0_gap1", {28'd0, gnt}, 32'd0);
    exp_own = 2'd1;
    cyc();
    burst_reads(3, 2'd1);
    req = 4'b1011;
    #1;
    burst_reads(5, 2'd1);
    chk("p0_gap2", {28'd0, gnt}, 32'd0);
    cyc();
`ifdef FIFO_RD_ARB_PRIO0_EN
    chk("p0_next", {28'd0, gnt}, 32'h1);
`else
    chk("p0_next", {28'd0, gnt}, 32'h8);
`endif
    req = 4'b0000;
    #1;
    cyc();
    chk("p0_idle", {28'd0, gnt}, 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
